// File: rtl/binary_enc_dec_pkg.sv
// Shared definitions for the binary_enc_dec library group.
//
// Contents:
//   state_e - occupancy state of the two-entry skid buffer (EMPTY, ONE, FULL).
//   decode  - pure binary-to-one-hot decode returning {unary, oor}, where oor
//             is in bit 0 and the unary vector sits above it.
//
// decode is sized to the package-level limits below. Callers narrow the
// result with a size cast to their own UNARY_WIDTH+1. Widths above
// MAX_UNARY_WIDTH are not supported.
package binary_enc_dec_pkg;

  localparam int MAX_UNARY_WIDTH = 1024;
  localparam int MAX_BIN_WIDTH   = $clog2(MAX_UNARY_WIDTH);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  // The index is compared against the caller's real width, not the
  // package limit, so indices in the gap between the two still flag oor.
  function automatic logic [MAX_UNARY_WIDTH:0] decode(
    input logic                     en,
    input logic [MAX_BIN_WIDTH-1:0] bin,
    input int unsigned              unaryWidth
  );
    logic [MAX_UNARY_WIDTH-1:0] unary;
    logic                       oor;
    unary = '0;
    oor   = 1'b0;
    if (en) begin
      if (32'(bin) < unaryWidth) begin
        unary[bin] = 1'b1;
      end else begin
        oor = 1'b1;
      end
    end
    return {unary, oor};
  endfunction

endpackage

// File: rtl/binary_decoder_skid.sv
// Generic two-entry skid buffer with registered outputs.
//
// Ports:
//   i_clk, i_rst       - clock and synchronous active-high reset
//   i_valid, o_ready   - input handshake
//   i_data [WIDTH]     - input payload
//   o_valid, i_ready   - output handshake
//   o_data [WIDTH]     - output payload, driven straight from the main register
//
// o_ready depends only on registered state and i_rst. No combinational
// path runs from i_ready to o_ready.
module binary_decoder_skid
  import binary_enc_dec_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  state_e           r_state;
  state_e           w_nextState;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             w_push;
  logic             w_pop;
  logic             w_loadMainIn;
  logic             w_loadMainSkid;
  logic             w_loadSkid;

  assign o_ready = !i_rst && (r_state != FULL);
  assign o_valid = (r_state != EMPTY);
  assign o_data  = r_main;

  assign w_push = i_valid & o_ready;
  assign w_pop  = o_valid & i_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      EMPTY: begin
        if (w_push) w_nextState = ONE;
      end
      ONE: begin
        if (w_pop && !w_push) begin
          w_nextState = EMPTY;
        end else if (w_push && !w_pop) begin
          w_nextState = FULL;
        end
      end
      FULL: begin
        if (w_pop) w_nextState = ONE;
      end
      default: w_nextState = EMPTY;
    endcase
  end

  // The skid entry is only ever written when main stays occupied and is
  // only ever drained into main, which keeps the ordering strictly FIFO.
  always_comb begin
    w_loadMainIn   = 1'b0;
    w_loadMainSkid = 1'b0;
    w_loadSkid     = 1'b0;
    case (r_state)
      EMPTY: begin
        w_loadMainIn = w_push;
      end
      ONE: begin
        w_loadMainIn = w_push & w_pop;
        w_loadSkid   = w_push & !w_pop;
      end
      FULL: begin
        w_loadMainSkid = w_pop;
      end
      default: begin
        w_loadMainIn = 1'b0;
      end
    endcase
  end

  // Payloads are cleared at reset so the outputs read zero, and are
  // otherwise held when no load is requested.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_loadMainIn) begin
        r_main <= i_data;
      end else if (w_loadMainSkid) begin
        r_main <= r_skid;
      end
      if (w_loadSkid) begin
        r_skid <= i_data;
      end
    end
  end

endmodule

// File: rtl/binary_decoder_pipe.sv
// Registered, flow-controlled binary-to-one-hot decoder.
//
// Ports:
//   i_clk, i_rst     - clock and synchronous active-high reset
//   i_valid, o_ready - input handshake, with beat fields i_en and i_bin
//   i_en             - 0 forces an all-zero decode with oor = 0
//   i_bin            - binary index
//   o_valid, i_ready - output handshake
//   o_unary          - decoded one-hot vector (zero when i_en = 0 or out of range)
//   o_oor            - i_bin >= UNARY_WIDTH while i_en = 1
//
// The beat is decoded before capture. A two-entry skid buffer registers
// the outputs and still sustains one beat per cycle.
module binary_decoder_pipe
  import binary_enc_dec_pkg::*;
#(
  parameter  int UNARY_WIDTH = 256,
  localparam int BIN_WIDTH   = $clog2(UNARY_WIDTH)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic                   i_en,
  input  logic [BIN_WIDTH-1:0]   i_bin,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [UNARY_WIDTH-1:0] o_unary,
  output logic                   o_oor
);

  logic [UNARY_WIDTH:0] w_inPayload;
  logic [UNARY_WIDTH:0] w_outPayload;

  // The package decode is sized to its global limit. The low UNARY_WIDTH+1
  // bits hold exactly {unary, oor} for this width.
  assign w_inPayload = (UNARY_WIDTH + 1)'(decode(i_en, MAX_BIN_WIDTH'(i_bin), UNARY_WIDTH));

  binary_decoder_skid #(
    .WIDTH (UNARY_WIDTH + 1)
  ) u_skid (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (w_inPayload),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (w_outPayload)
  );

  assign o_unary = w_outPayload[UNARY_WIDTH:1];
  assign o_oor   = w_outPayload[0];

endmodule
